ysyx_22041461_dcache_assoc: RTL

//  Parametrised N-way set-associative, write-through, read-allocate data cache for the LSU.
//  One 64-bit word per line. Uncached regions bypass to memory.

---
 rtl/ysyx_22041461_dcache_assoc.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041461_dcache_assoc.sv
// N-way set-associative, write-through, read-allocate data cache between the LSU and memory.
// Define DCACHE_PERF_EN to add the perf_hit / perf_miss load counters.
module ysyx_22041461_dcache_assoc #(
    parameter int          WAYS        = 2,
    parameter int          SETS        = 64,
    parameter logic [63:0] CACHE_BASE  = 64'h0000_0000_8000_0000,
    parameter logic [63:0] CACHE_LIMIT = 64'h0000_0000_8fff_ffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    input  logic        flush,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 61 - INDEX_W;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR, S_REFILL, S_RESP
    } state_t;

    state_t                        r_state, w_state_next;
    logic [63:0]                   r_addr, r_wdata, r_ld_data, r_resp_rdata;
    logic [7:0]                    r_wmask;
    logic                          r_wen, r_hit;
    logic [WAY_W-1:0]              r_hit_way;
    logic [WAYS-1:0][SETS-1:0]     r_valid;
    logic [SETS-1:0][WAY_W-1:0]    r_ptr;

    logic [INDEX_W-1:0]            w_idx, w_req_idx;
    logic [TAG_W-1:0]              w_tag;
    logic                          w_cached, w_accept, w_flush, w_hit;
    logic [WAYS-1:0]               w_hit_vec;
    logic [WAYS-1:0][63:0]         w_data_rd;
    logic [WAY_W-1:0]              w_hit_way, w_victim, w_arr_way;
    logic [63:0]                   w_hit_data, w_merge, w_arr_wdata;
    logic                          w_arr_we;

    assign w_idx     = r_addr[INDEX_W+2:3];
    assign w_tag     = r_addr[63:INDEX_W+3];
    assign w_req_idx = req_addr[INDEX_W+2:3];
    assign w_cached  = (r_addr >= CACHE_BASE) && (r_addr <= CACHE_LIMIT);
    assign w_accept  = req_valid && req_ready;
    assign w_flush   = (r_state == S_IDLE) && flush;
    assign w_hit     = |w_hit_vec;

    // Per-way tag/data RAMs; the read is registered on accept so LOOKUP sees the set.
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [63:0]      r_data_mem [SETS];
        logic [TAG_W-1:0] r_tag_mem  [SETS];
        logic [63:0]      r_data_rd;
        logic [TAG_W-1:0] r_tag_rd;

        always_ff @(posedge clk) begin
            if (w_arr_we && (w_arr_way == WAY_W'(gi))) begin
                r_data_mem[w_idx] <= w_arr_wdata;
                r_tag_mem[w_idx]  <= w_tag;
            end
            if (w_accept) begin
                r_data_rd <= r_data_mem[w_req_idx];
                r_tag_rd  <= r_tag_mem[w_req_idx];
            end
        end

        assign w_data_rd[gi] = r_data_rd;
        assign w_hit_vec[gi] = r_valid[gi][w_idx] && (r_tag_rd == w_tag);
    end

    always_comb begin
        w_hit_way  = '0;
        w_hit_data = '0;
        w_victim   = r_ptr[w_idx];
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) begin
                w_hit_way  = WAY_W'(i);
                w_hit_data = w_data_rd[i];
            end
            if (!r_valid[i][w_idx]) w_victim = WAY_W'(i);
        end
    end

    always_comb begin
        w_merge = w_data_rd[r_hit_way];
        for (int b = 0; b < 8; b++) begin
            if (r_wmask[b]) w_merge[b*8 +: 8] = r_wdata[b*8 +: 8];
        end
    end

    assign w_arr_we    = (r_state == S_REFILL) ||
                         ((r_state == S_MEM_WR) && mem_ack && r_hit && w_cached);
    assign w_arr_way   = (r_state == S_REFILL) ? w_victim : r_hit_way;
    assign w_arr_wdata = (r_state == S_REFILL) ? r_ld_data : w_merge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        mem_req      = 1'b0;
        mem_wen      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) w_state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (r_wen)                  w_state_next = S_MEM_WR;
                else if (w_hit && w_cached) w_state_next = S_RESP;
                else                        w_state_next = S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                if (mem_ack) w_state_next = w_cached ? S_REFILL : S_RESP;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_wen = 1'b1;
                if (mem_ack) w_state_next = S_RESP;
            end
            S_REFILL: w_state_next = S_RESP;
            S_RESP: begin
                resp_valid   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // resp_rdata is only rewritten on the edge that enters RESP, so it holds between responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_wen        <= 1'b0;
            r_hit        <= 1'b0;
            r_hit_way    <= '0;
            r_valid      <= '0;
            r_ptr        <= '0;
            r_ld_data    <= '0;
            r_resp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_wmask <= req_wmask;
                r_wen   <= req_wen;
            end
            if (w_flush) begin
                r_valid <= '0;
                r_ptr   <= '0;
            end
            case (r_state)
                S_LOOKUP: begin
                    r_hit     <= w_hit;
                    r_hit_way <= w_hit_way;
                    if (!r_wen && w_hit && w_cached) r_resp_rdata <= w_hit_data;
                end
                S_MEM_RD: if (mem_ack) begin
                    r_ld_data <= mem_rdata;
                    if (!w_cached) r_resp_rdata <= mem_rdata;
                end
                S_MEM_WR: if (mem_ack) r_resp_rdata <= '0;
                S_REFILL: begin
                    r_valid[w_victim][w_idx] <= 1'b1;
                    if (w_victim == r_ptr[w_idx])
                        r_ptr[w_idx] <= WAY_W'((int'(r_ptr[w_idx]) + 1) % WAYS);
                    r_resp_rdata <= r_ld_data;
                end
                default: ;
            endcase
        end
    end

    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign mem_wmask  = r_wmask;

`ifdef DCACHE_PERF_EN
    logic [31:0] r_perf_hit, r_perf_miss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else if ((r_state == S_LOOKUP) && !r_wen && w_cached) begin
            if (w_hit) r_perf_hit  <= r_perf_hit + 32'd1;
            else       r_perf_miss <= r_perf_miss + 32'd1;
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif
endmodule
